time_entry_encoder: RTL and testbench
=====================================

TIME_ENTRY_ENCODER -- requirements
Module: time_entry_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse; begins (or restarts) an entry session.
REQ-004 SHALL have ports: cancel  in  1  one-cycle pulse; aborts the session.
REQ-005 SHALL have ports: digit_valid  in  1  qualifies digit for one cycle.
REQ-006 SHALL have ports: digit  in  4  keyed value; 0-9 legal, 10-15 illegal.
REQ-007 SHALL have ports: out_time  out  21  live packed HH|MM|SS as {[20:14],[13:7],[6:0]}, binary 0-99 per field; 7'h7F = unset field (shows hyphens).
REQ-008 SHALL have ports: target  out  2  field under edit: 2'd2 LEFT (hours), 2'd1 MID (minutes), 2'd0 RIGHT (seconds).
REQ-009 SHALL have ports: busy  out  1  high while a session is active.
REQ-010 SHALL have ports: commit_valid  out  1  one-cycle pulse when a complete, legal time is committed.
REQ-011 SHALL have ports: commit_time  out  21  last committed packed time, held until the next commit.
REQ-012 SHALL have ports: error  out  1  one-cycle pulse on each rejected digit.

Function
REQ-013 All outputs SHALL be registered; each response appears on the cycle after the triggering input edge (latency 1).
REQ-014 FSM states SHALL be IDLE, TENS, ONES, COMMIT; field index SHALL step LEFT -> MID -> RIGHT.
REQ-015 IDLE + start SHALL enter TENS with target=LEFT, out_time=21'h1FFFFF, busy=1.
REQ-016 TENS + legal digit SHALL latch the digit as tens, go to ONES; the field stays 7'h7F.
REQ-017 ONES + legal digit SHALL write tens*10+ones (7-bit) into the target field; then go to TENS of next field, or to COMMIT after RIGHT.
REQ-018 Legality: digit <=9; hours tens <=2, hours value <=23; minutes/seconds tens <=5.
REQ-019 Illegal digit SHALL pulse error, leave state, field, latched tens and out_time unchanged.
REQ-020 COMMIT SHALL last one cycle: commit_time<=out_time, commit_valid=1, busy=0, target=LEFT; return to IDLE with out_time holding committed value.
REQ-021 cancel SHALL in any non-IDLE state return to IDLE, busy=0, out_time<=commit_time, target=LEFT, no commit_valid.
REQ-022 Priority in one cycle SHALL be cancel > start > digit_valid; a simultaneous digit is dropped without error.
REQ-023 start while busy SHALL restart at LEFT/TENS with all fields reset to 7'h7F.
REQ-024 digit_valid in IDLE or COMMIT SHALL be ignored with no error.
REQ-025 commit_valid and error SHALL never both be high.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, out_time=21'h1FFFFF, commit_time=21'h1FFFFF, target=2'd2, busy=0, commit_valid=0, error=0, latched tens=0.
REQ-027 Reset asserted mid-session SHALL discard the partial entry; no commit pulse on release.

Structure
REQ-028 Shared package SHALL hold: field codes LEFT/MID/RIGHT, UNSET_FIELD=7'h7F, MAX_HOUR=23, MAX_MINSEC=59, FSM state enum.
REQ-029 One sub-module digit_encoder SHALL combine tens/ones BCD into a 7-bit binary field and flag range violation against a supplied limit (inverse of the display-side digit decoder).

Verification
REQ-030 reset; start; digits 1,2,3,4,5,6 -> commit_valid one cycle after '6', commit_time=={7'd12,7'd34,7'd56}, busy=0.
REQ-031 start; digit 3 at hours tens -> error pulse, target=2, out_time=21'h1FFFFF, next digit 1 accepted as tens.
REQ-032 start; digits 2,4 -> error on '4', hours field still 7'h7F; then 3 -> hours=23, target=1.
REQ-033 after commit of 12:34:56, start; 0,9,1; cancel -> busy=0, no commit_valid, out_time==commit_time=={12,34,56}.
REQ-034 digit 4'd10 in TENS, and cancel+digit_valid same cycle -> error on first only; second returns IDLE without error.
REQ-035 reset_n low mid-session after 4 digits -> all outputs at reset values same cycle; after release start; 0,0,0,0,0,0 commits 21'd0.

Source files
------------

// File: rtl/time_entry_encoder_pkg.sv
// Shared definitions for the keypad time-entry encoder: field codes, limits and FSM states.
// Fields are packed HH|MM|SS; an unset field reads as 7'h7F so the display shows hyphens.
package time_entry_encoder_pkg;

   localparam logic [1:0]  FIELD_LEFT  = 2'd2;
   localparam logic [1:0]  FIELD_MID   = 2'd1;
   localparam logic [1:0]  FIELD_RIGHT = 2'd0;

   localparam logic [6:0]  UNSET_FIELD = 7'h7F;
   localparam logic [6:0]  MAX_HOUR    = 7'd23;
   localparam logic [6:0]  MAX_MINSEC  = 7'd59;
   localparam logic [20:0] UNSET_TIME  = {UNSET_FIELD, UNSET_FIELD, UNSET_FIELD};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TENS   = 2'd1,
      ST_ONES   = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   function automatic logic [6:0] field_limit(input logic [1:0] field);
      logic [6:0] lim;
      case (field)
         FIELD_LEFT: lim = MAX_HOUR;
         default:    lim = MAX_MINSEC;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/time_entry_encoder_digit_encoder.sv
// Combines a tens/ones BCD pair into a 7-bit binary field and flags any digit above 9
// or a combined value above the supplied limit.
module digit_encoder
   import time_entry_encoder_pkg::*;
(
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic [6:0] limit,
   output logic [6:0] value,
   output logic       over
);

   logic [7:0] sum_s;

   // Binary value and range check
   always_comb begin
      sum_s = ({4'd0, tens} * 8'd10) + {4'd0, ones};
      value = sum_s[6:0];
      over  = (tens > 4'd9) || (ones > 4'd9) || (sum_s > {1'b0, limit});
   end

endmodule

// File: rtl/time_entry_encoder.sv
// Keypad time-entry encoder: collects HH, MM, SS as tens/ones digit pairs, validates each
// digit against the field range and commits a complete legal time as a one-cycle pulse.
module time_entry_encoder
   import time_entry_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        cancel,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   output logic [20:0] out_time,
   output logic [1:0]  target,
   output logic        busy,
   output logic        commit_valid,
   output logic [20:0] commit_time,
   output logic        error
);

   state_t      state_r;
   logic [3:0]  tens_r;
   logic [1:0]  target_r;
   logic [20:0] out_time_r;
   logic [20:0] commit_time_r;
   logic        busy_r;
   logic        commit_valid_r;
   logic        error_r;

   logic [3:0]  enc_tens_s;
   logic [3:0]  enc_ones_s;
   logic [6:0]  field_value_s;
   logic        field_over_s;
   logic [20:0] field_time_s;

   // A tens digit is checked as "d0" against the field limit, which yields the tens bound
   always_comb begin
      if (state_r == ST_ONES) begin
         enc_tens_s = tens_r;
         enc_ones_s = digit;
      end else begin
         enc_tens_s = digit;
         enc_ones_s = 4'd0;
      end
   end

   digit_encoder u_digit_encoder (
      .tens  (enc_tens_s),
      .ones  (enc_ones_s),
      .limit (field_limit(target_r)),
      .value (field_value_s),
      .over  (field_over_s)
   );

   // Current time with the field under edit replaced by the encoded value
   always_comb begin
      field_time_s = out_time_r;
      case (target_r)
         FIELD_LEFT:  field_time_s[20:14] = field_value_s;
         FIELD_MID:   field_time_s[13:7]  = field_value_s;
         FIELD_RIGHT: field_time_s[6:0]   = field_value_s;
         default:     field_time_s        = out_time_r;
      endcase
   end

   // Session FSM; cancel outranks start, which outranks a digit in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         tens_r         <= 4'd0;
         target_r       <= FIELD_LEFT;
         out_time_r     <= UNSET_TIME;
         commit_time_r  <= UNSET_TIME;
         busy_r         <= 1'b0;
         commit_valid_r <= 1'b0;
         error_r        <= 1'b0;
      end else begin
         commit_valid_r <= 1'b0;
         error_r        <= 1'b0;
         if (cancel) begin
            state_r    <= ST_IDLE;
            tens_r     <= 4'd0;
            target_r   <= FIELD_LEFT;
            out_time_r <= commit_time_r;
            busy_r     <= 1'b0;
         end else if (start) begin
            state_r    <= ST_TENS;
            tens_r     <= 4'd0;
            target_r   <= FIELD_LEFT;
            out_time_r <= UNSET_TIME;
            busy_r     <= 1'b1;
         end else if (state_r == ST_COMMIT) begin
            state_r <= ST_IDLE;
         end else if (digit_valid && (state_r == ST_TENS || state_r == ST_ONES)) begin
            if (field_over_s) begin
               error_r <= 1'b1;
            end else if (state_r == ST_TENS) begin
               tens_r  <= digit;
               state_r <= ST_ONES;
            end else begin
               out_time_r <= field_time_s;
               tens_r     <= 4'd0;
               if (target_r == FIELD_RIGHT) begin
                  state_r        <= ST_COMMIT;
                  commit_time_r  <= field_time_s;
                  commit_valid_r <= 1'b1;
                  busy_r         <= 1'b0;
                  target_r       <= FIELD_LEFT;
               end else begin
                  state_r  <= ST_TENS;
                  target_r <= target_r - 2'd1;
               end
            end
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign out_time     = out_time_r;
   assign target       = target_r;
   assign busy         = busy_r;
   assign commit_valid = commit_valid_r;
   assign commit_time  = commit_time_r;
   assign error        = error_r;

endmodule

// File: tb/tb_time_entry_encoder.sv
// Directed table-driven bench for time_entry_encoder with hand-computed expectations,
// plus a hand-written reset-during-session sequence.
module tb_time_entry_encoder;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        cancel;
   logic        digit_valid;
   logic [3:0]  digit;
   logic [20:0] out_time;
   logic [1:0]  target;
   logic        busy;
   logic        commit_valid;
   logic [20:0] commit_time;
   logic        error;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [6:0]  U    = 7'h7F;
   localparam logic [20:0] FULL = 21'h1FFFFF;

   typedef struct {
      logic        st;
      logic        cn;
      logic        dv;
      logic [3:0]  dg;
      logic [20:0] e_time;
      logic [1:0]  e_tgt;
      logic        e_busy;
      logic        e_cv;
      logic [20:0] e_ct;
      logic        e_err;
   } vec_t;

   vec_t vecs [32];
   vec_t zvec [7];

   time_entry_encoder dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .cancel       (cancel),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .out_time     (out_time),
      .target       (target),
      .busy         (busy),
      .commit_valid (commit_valid),
      .commit_time  (commit_time),
      .error        (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [20:0] pk(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
      return {h, m, s};
   endfunction

   function automatic vec_t mk(input logic st, input logic cn, input logic dv, input logic [3:0] dg,
                               input logic [20:0] t, input logic [1:0] tg, input logic b,
                               input logic cv, input logic [20:0] ct, input logic er);
      vec_t v;
      v.st = st; v.cn = cn; v.dv = dv; v.dg = dg;
      v.e_time = t; v.e_tgt = tg; v.e_busy = b; v.e_cv = cv; v.e_ct = ct; v.e_err = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input vec_t v);
      check({tag, "_time"},   {11'd0, out_time}, {11'd0, v.e_time});
      check({tag, "_target"}, {30'd0, target},   {30'd0, v.e_tgt});
      check({tag, "_busy"},   {31'd0, busy},     {31'd0, v.e_busy});
      check({tag, "_cv"},     {31'd0, commit_valid}, {31'd0, v.e_cv});
      check({tag, "_ctime"},  {11'd0, commit_time},  {11'd0, v.e_ct});
      check({tag, "_err"},    {31'd0, error},    {31'd0, v.e_err});
   endtask

   // Drive at the falling edge, let one rising edge pass, compare at the next falling edge
   task automatic apply(input string tag, input vec_t v);
      start       = v.st;
      cancel      = v.cn;
      digit_valid = v.dv;
      digit       = v.dg;
      @(negedge clk);
      check_outputs(tag, v);
   endtask

   initial begin
      logic [20:0] c;
      vec_t rv;
      c = pk(7'd12, 7'd34, 7'd56);

      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 4'd0, FULL, 2'd2, 1'b1, 1'b0, FULL, 1'b0);
      vecs[1]  = mk(1'b0, 1'b0, 1'b1, 4'd1, FULL, 2'd2, 1'b1, 1'b0, FULL, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b1, 4'd2, pk(7'd12, U, U), 2'd1, 1'b1, 1'b0, FULL, 1'b0);
      vecs[3]  = mk(1'b0, 1'b0, 1'b1, 4'd3, pk(7'd12, U, U), 2'd1, 1'b1, 1'b0, FULL, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 1'b1, 4'd4, pk(7'd12, 7'd34, U), 2'd0, 1'b1, 1'b0, FULL, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 1'b1, 4'd5, pk(7'd12, 7'd34, U), 2'd0, 1'b1, 1'b0, FULL, 1'b0);
      vecs[6]  = mk(1'b0, 1'b0, 1'b1, 4'd6, c, 2'd2, 1'b0, 1'b1, c, 1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 4'd0, c, 2'd2, 1'b0, 1'b0, c, 1'b0);
      vecs[8]  = mk(1'b1, 1'b0, 1'b0, 4'd0, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[9]  = mk(1'b0, 1'b0, 1'b1, 4'd0, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 4'd9, pk(7'd9, U, U), 2'd1, 1'b1, 1'b0, c, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 4'd1, pk(7'd9, U, U), 2'd1, 1'b1, 1'b0, c, 1'b0);
      vecs[12] = mk(1'b0, 1'b1, 1'b0, 4'd0, c, 2'd2, 1'b0, 1'b0, c, 1'b0);
      vecs[13] = mk(1'b1, 1'b0, 1'b0, 4'd0, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[14] = mk(1'b0, 1'b0, 1'b1, 4'd3, FULL, 2'd2, 1'b1, 1'b0, c, 1'b1);
      vecs[15] = mk(1'b0, 1'b0, 1'b1, 4'd1, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[16] = mk(1'b0, 1'b0, 1'b1, 4'd2, pk(7'd12, U, U), 2'd1, 1'b1, 1'b0, c, 1'b0);
      vecs[17] = mk(1'b1, 1'b0, 1'b0, 4'd0, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[18] = mk(1'b0, 1'b0, 1'b1, 4'd2, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[19] = mk(1'b0, 1'b0, 1'b1, 4'd4, FULL, 2'd2, 1'b1, 1'b0, c, 1'b1);
      vecs[20] = mk(1'b0, 1'b0, 1'b1, 4'd3, pk(7'd23, U, U), 2'd1, 1'b1, 1'b0, c, 1'b0);
      vecs[21] = mk(1'b0, 1'b0, 1'b1, 4'd6, pk(7'd23, U, U), 2'd1, 1'b1, 1'b0, c, 1'b1);
      vecs[22] = mk(1'b0, 1'b0, 1'b1, 4'd5, pk(7'd23, U, U), 2'd1, 1'b1, 1'b0, c, 1'b0);
      vecs[23] = mk(1'b0, 1'b0, 1'b1, 4'd9, pk(7'd23, 7'd59, U), 2'd0, 1'b1, 1'b0, c, 1'b0);
      vecs[24] = mk(1'b0, 1'b0, 1'b1, 4'd10, pk(7'd23, 7'd59, U), 2'd0, 1'b1, 1'b0, c, 1'b1);
      vecs[25] = mk(1'b0, 1'b1, 1'b1, 4'd1, c, 2'd2, 1'b0, 1'b0, c, 1'b0);
      vecs[26] = mk(1'b0, 1'b0, 1'b1, 4'd5, c, 2'd2, 1'b0, 1'b0, c, 1'b0);
      vecs[27] = mk(1'b1, 1'b0, 1'b1, 4'd1, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[28] = mk(1'b0, 1'b0, 1'b1, 4'd1, FULL, 2'd2, 1'b1, 1'b0, c, 1'b0);
      vecs[29] = mk(1'b0, 1'b0, 1'b1, 4'd9, pk(7'd19, U, U), 2'd1, 1'b1, 1'b0, c, 1'b0);
      vecs[30] = mk(1'b0, 1'b0, 1'b1, 4'd2, pk(7'd19, U, U), 2'd1, 1'b1, 1'b0, c, 1'b0);
      vecs[31] = mk(1'b0, 1'b0, 1'b1, 4'd3, pk(7'd19, 7'd23, U), 2'd0, 1'b1, 1'b0, c, 1'b0);

      zvec[0] = mk(1'b1, 1'b0, 1'b0, 4'd0, FULL, 2'd2, 1'b1, 1'b0, FULL, 1'b0);
      zvec[1] = mk(1'b0, 1'b0, 1'b1, 4'd0, FULL, 2'd2, 1'b1, 1'b0, FULL, 1'b0);
      zvec[2] = mk(1'b0, 1'b0, 1'b1, 4'd0, pk(7'd0, U, U), 2'd1, 1'b1, 1'b0, FULL, 1'b0);
      zvec[3] = mk(1'b0, 1'b0, 1'b1, 4'd0, pk(7'd0, U, U), 2'd1, 1'b1, 1'b0, FULL, 1'b0);
      zvec[4] = mk(1'b0, 1'b0, 1'b1, 4'd0, pk(7'd0, 7'd0, U), 2'd0, 1'b1, 1'b0, FULL, 1'b0);
      zvec[5] = mk(1'b0, 1'b0, 1'b1, 4'd0, pk(7'd0, 7'd0, U), 2'd0, 1'b1, 1'b0, FULL, 1'b0);
      zvec[6] = mk(1'b0, 1'b0, 1'b1, 4'd0, 21'd0, 2'd2, 1'b0, 1'b1, 21'd0, 1'b0);

      rv = mk(1'b0, 1'b0, 1'b0, 4'd0, FULL, 2'd2, 1'b0, 1'b0, FULL, 1'b0);

      reset_n     = 1'b0;
      start       = 1'b0;
      cancel      = 1'b0;
      digit_valid = 1'b0;
      digit       = 4'd0;
      @(negedge clk);
      @(negedge clk);
      check_outputs("reset", rv);
      reset_n = 1'b1;

      for (int i = 0; i < 32; i++) begin
         apply($sformatf("v%0d", i), vecs[i]);
      end

      // Four digits are in flight; reset between clock edges must clear everything at once
      start       = 1'b0;
      cancel      = 1'b0;
      digit_valid = 1'b0;
      digit       = 4'd0;
      #2 reset_n = 1'b0;
      #1 check_outputs("midrst", rv);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_outputs("postrst", rv);

      for (int i = 0; i < 7; i++) begin
         apply($sformatf("z%0d", i), zvec[i]);
      end
      apply("zidle", mk(1'b0, 1'b0, 1'b0, 4'd0, 21'd0, 2'd2, 1'b0, 1'b0, 21'd0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
